// File: rtl/seg_entry_ctrl.sv
// seg_entry_ctrl: debounced short/long button entry into a digit buffer with a blinking cursor.
// Define SEG_ENTRY_SHIFT_EN for shift-register entry (long press clears, no blink).
module seg_entry_ctrl #(
    parameter int NUM_SEG   = 6,
    parameter int DEB_CYC   = 20,
    parameter int LONG_CYC  = 1000,
    parameter int BLINK_CYC = 500
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 btn,
    input  logic [3:0]           sw,
    output logic [4*NUM_SEG-1:0] digits,
    output logic [NUM_SEG-1:0]   blank,
    output logic [2:0]           cursor,
    output logic                 wr_pulse,
    output logic [2:0]           wr_idx
);
    localparam int DW = $clog2(DEB_CYC);
    localparam int HW = $clog2(LONG_CYC);

    typedef enum logic [1:0] {IDLE, PRESS, LONG} state_t;

    state_t          state, state_n;
    logic            btn_m, btn_s, btn_db;
    logic [3:0]      sw_m, sw_s;
    logic [DW-1:0]   deb_cnt;
    logic [HW-1:0]   hold_cnt;
    logic            short_act, long_act;
`ifndef SEG_ENTRY_SHIFT_EN
    localparam int BW = $clog2(BLINK_CYC);
    logic [BW-1:0]   blink_cnt;
    logic            phase;
`endif

    // Release wins over long detection when both land on the same cycle.
    always_comb begin
        state_n   = state;
        short_act = 1'b0;
        long_act  = 1'b0;
        case (state)
            IDLE:    if (!btn_db) state_n = PRESS;
            PRESS:   if (btn_db) begin
                         short_act = 1'b1;
                         state_n   = IDLE;
                     end else if (hold_cnt == HW'(LONG_CYC - 1)) begin
                         long_act = 1'b1;
                         state_n  = LONG;
                     end
            LONG:    if (btn_db) state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            btn_m     <= 1'b1;
            btn_s     <= 1'b1;
            btn_db    <= 1'b1;
            sw_m      <= '0;
            sw_s      <= '0;
            deb_cnt   <= '0;
            hold_cnt  <= '0;
            state     <= IDLE;
            digits    <= '0;
            blank     <= '0;
            cursor    <= '0;
            wr_pulse  <= 1'b0;
            wr_idx    <= '0;
`ifndef SEG_ENTRY_SHIFT_EN
            blink_cnt <= '0;
            phase     <= 1'b0;
`endif
        end else begin
            btn_m    <= btn;
            btn_s    <= btn_m;
            sw_m     <= sw;
            sw_s     <= sw_m;
            deb_cnt  <= (btn_s == btn_db || deb_cnt == DW'(DEB_CYC - 1)) ? '0 : deb_cnt + 1'b1;
            if (btn_s != btn_db && deb_cnt == DW'(DEB_CYC - 1)) btn_db <= btn_s;
            state    <= state_n;
            hold_cnt <= (state == PRESS) ? hold_cnt + 1'b1 : '0;
            wr_pulse <= short_act;
`ifdef SEG_ENTRY_SHIFT_EN
            if (short_act) begin
                digits <= {digits[4*NUM_SEG-5:0], sw_s};
                wr_idx <= '0;
            end
            if (long_act) begin
                digits <= '0;
                cursor <= '0;
            end
            blank <= '0;
`else
            if (short_act) begin
                digits[4*cursor +: 4] <= sw_s;
                wr_idx                <= cursor;
            end
            if (long_act) cursor <= (cursor == 3'(NUM_SEG - 1)) ? 3'd0 : cursor + 3'd1;
            blink_cnt <= (blink_cnt == BW'(BLINK_CYC - 1)) ? '0 : blink_cnt + 1'b1;
            if (blink_cnt == BW'(BLINK_CYC - 1)) phase <= ~phase;
            // Cursor digit stays lit while the button is held.
            blank <= (state == IDLE && phase) ? NUM_SEG'(1) << cursor : '0;
`endif
        end
    end
endmodule

// File: tb/tb_seg_entry_ctrl.sv
// tb_seg_entry_ctrl: directed and random presses checked against a press-level model.
module tb_seg_entry_ctrl;
    localparam int N = 6, DEB = 4, LNG = 16, BLK = 8;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic           btn = 1'b1;
    logic [3:0]     sw = 4'h0;
    logic [4*N-1:0] digits;
    logic [N-1:0]   blank;
    logic [2:0]     cursor;
    logic           wr_pulse;
    logic [2:0]     wr_idx;

    int         errors = 0, checks = 0, pulses = 0;
    logic [2:0] last_idx = '0;
    logic [3:0] m_dig[N];
    int         m_cur;

    seg_entry_ctrl #(.NUM_SEG(N), .DEB_CYC(DEB), .LONG_CYC(LNG), .BLINK_CYC(BLK)) dut (
        .clk(clk), .rst_n(rst_n), .btn(btn), .sw(sw), .digits(digits),
        .blank(blank), .cursor(cursor), .wr_pulse(wr_pulse), .wr_idx(wr_idx)
    );

    always #5 clk = ~clk;

    always @(negedge clk) if (wr_pulse === 1'b1) begin
        pulses++;
        last_idx = wr_idx;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [4*N-1:0] m_digits();
        logic [4*N-1:0] r;
        for (int i = 0; i < N; i++) r[4*i +: 4] = m_dig[i];
        return r;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < N; i++) m_dig[i] = 4'h0;
        m_cur = 0;
    endtask

    // A clean press of len raw cycles is long exactly when len exceeds LONG_CYC.
    task automatic press(input int len, input logic [3:0] v);
        int p0, exp_idx;
        bit is_long;
        p0 = pulses;
        is_long = len > LNG;
        sw = v;
        @(negedge clk);
        btn = 1'b0;
        for (int i = 0; i < len; i++) begin
            @(negedge clk);
            if (i == 9) check("blank_held", blank, 0);
        end
        btn = 1'b1;
        repeat (30) @(negedge clk);
`ifdef SEG_ENTRY_SHIFT_EN
        exp_idx = 0;
        if (is_long) model_reset();
        else begin
            for (int i = N - 1; i > 0; i--) m_dig[i] = m_dig[i-1];
            m_dig[0] = v;
        end
`else
        exp_idx = m_cur;
        if (is_long) m_cur = (m_cur + 1) % N;
        else m_dig[m_cur] = v;
`endif
        check("pulses", pulses - p0, is_long ? 0 : 1);
        if (!is_long) check("wr_idx", last_idx, exp_idx);
        check("digits", digits, m_digits());
        check("cursor", cursor, m_cur);
    endtask

    initial begin
        int p0, n;
        bit ok;
        logic [N-1:0] b0, b1, oh;
        model_reset();
        rst_n = 1'b0;
        btn = 1'b0;
        sw = 4'hF;
        repeat (3) @(negedge clk);
        check("rst_digits", digits, 0);
        check("rst_blank", blank, 0);
        check("rst_cursor", cursor, 0);
        check("rst_wr_pulse", wr_pulse, 0);
        check("rst_wr_idx", wr_idx, 0);
        btn = 1'b1;
        rst_n = 1'b1;
        repeat (20) @(negedge clk);
        check("rst_no_write", pulses, 0);
        check("rst_digits_after", digits, 0);

        press(8, 4'hA);
        press(30, 4'h0);
        press(6, 4'h5);
        repeat (6) press(25, 4'h0);
        press(LNG, 4'h7);
        press(LNG + 1, 4'h0);
        press(DEB, 4'h3);

        // Glitches shorter than the debounce window must be invisible.
        p0 = pulses;
        repeat (13) begin
            btn = 1'b0;
            repeat (2) @(negedge clk);
            btn = 1'b1;
            @(negedge clk);
        end
        repeat (20) @(negedge clk);
        check("bounce_pulses", pulses - p0, 0);
        check("bounce_digits", digits, m_digits());
        check("bounce_cursor", cursor, m_cur);

`ifdef SEG_ENTRY_SHIFT_EN
        ok = 1'b1;
        repeat (20) begin
            @(negedge clk);
            if (blank !== '0) ok = 1'b0;
        end
        check("blank_off", ok, 1);
`else
        oh = N'(1) << m_cur;
        b0 = blank;
        n = 0;
        while (blank === b0 && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("blink_edge", n < 20, 1);
        b1 = blank;
        check("blink_val", b1, (b0 == '0) ? oh : '0);
        ok = 1'b1;
        repeat (BLK - 1) begin
            @(negedge clk);
            if (blank !== b1) ok = 1'b0;
        end
        check("blink_hold", ok, 1);
        @(negedge clk);
        check("blink_toggle", blank, b0);
`endif

        for (int k = 0; k < 12; k++) begin
            if ($urandom_range(0, 2) == 0) press($urandom_range(20, 40), 4'($urandom));
            else press($urandom_range(DEB, 14), 4'($urandom));
        end

        // Reset in the middle of a held press aborts it without a write.
        p0 = pulses;
        sw = 4'h9;
        @(negedge clk);
        btn = 1'b0;
        repeat (12) @(negedge clk);
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        btn = 1'b1;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (30) @(negedge clk);
        model_reset();
        check("midrst_pulses", pulses - p0, 0);
        check("midrst_digits", digits, 0);
        check("midrst_cursor", cursor, 0);
        press(5, 4'hC);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/seg_entry_ctrl.md
Name: seg_entry_ctrl

Overview:
- Operator-entry controller for the multi-digit 7-segment display path.
- Debounces the raw push-button and classifies each press as short or long. Short press writes the switch nibble into the digit under a cursor; long press advances the cursor.
- Drives packed digit nibbles and a per-digit blank mask. The blank mask blinks the cursor digit. The downstream seg_drv stage converts nibbles to segments.

Parameters:
- NUM_SEG, 6, number of digits (2..8).
- DEB_CYC, 20, consecutive stable cycles required to accept a new button level (>=2).
- LONG_CYC, 1000, held cycles that turn a press into a long press (>DEB_CYC).
- BLINK_CYC, 500, cycles per blink half-period (>=2).

Ports:
- clk  in  1  system clock.
- rst_n  in  1  reset; one clock; reset is synchronous and active-low.
- btn  in  1  raw push-button, asynchronous; 0 = pressed.
- sw  in  4  raw switch nibble, asynchronous.
- digits  out  4*NUM_SEG  digit i nibble at [4*i+:4].
- blank  out  NUM_SEG  1 = digit i dark.
- cursor  out  3  index of the digit being edited.
- wr_pulse  out  1  one-cycle strobe on every digit write.
- wr_idx  out  3  digit index written, valid with wr_pulse.

Behaviour:
- Reset (rst_n=0 at a clk edge) overrides everything:
  - digits=0, blank=0, cursor=0, wr_pulse=0, wr_idx=0.
  - btn_db=1 (released), FSM=IDLE, all counters=0, blink phase=0.
  - Reset asserted mid-press aborts the press with no write.
- Synchronisers: btn and sw each pass through 2 flops, giving btn_s and sw_s.
- Debounce:
  - deb_cnt clears whenever btn_s==btn_db; otherwise it increments.
  - When deb_cnt reaches DEB_CYC-1 while still differing: btn_db<=btn_s and deb_cnt<=0.
  - Glitches shorter than DEB_CYC cycles are ignored.
- FSM states IDLE, PRESS, LONG:
  - IDLE: btn_db==0 -> PRESS, hold_cnt<=0.
  - PRESS, btn_db==1 -> short action, then IDLE. Release has priority over long detection in the same cycle.
  - PRESS, else if hold_cnt==LONG_CYC-1 -> long action, then LONG.
  - PRESS, otherwise hold_cnt increments.
  - LONG: btn_db==1 -> IDLE, with no action.
  - A long press therefore never also writes.
- Short action, registered and visible on the cycle after the FSM sees release:
  - digits[cursor] <= sw_s sampled on the release cycle.
  - wr_pulse=1 for exactly one cycle; wr_idx=cursor.
- Long action: cursor <= (cursor==NUM_SEG-1) ? 0 : cursor+1. Wrap-around is required.
- Blink:
  - blink_cnt is free-running 0..BLINK_CYC-1; phase toggles on wrap.
  - blank[cursor] = phase when FSM==IDLE; all other bits 0.
  - blank is all 0 during PRESS and LONG, so the cursor digit stays lit while held.
  - blank is registered; it moves with cursor on the cycle after the cursor update.
- All outputs are registered. No combinational path exists from btn or sw to any output.

Optional Feature:
- Macro SEG_ENTRY_SHIFT_EN.
- Defined:
  - Short action shifts instead of indexing: digit0<=sw_s, digit[i+1]<=digit[i], top digit discarded.
  - wr_idx=0.
  - Long action clears all digits to 0 and sets cursor=0; no wr_pulse.
  - Blink is disabled, so blank is constant 0.
- Undefined: cursor-edit behaviour as above.

Test Plan:
- Common settings for all scenarios: NUM_SEG=6, DEB_CYC=4, LONG_CYC=16, BLINK_CYC=8.
- Reset: hold rst_n=0 3 cycles with btn=0, sw=F -> digits=0, blank=0, cursor=0, wr_pulse=0; release rst_n with btn=1 -> no write occurs.
- Short press: sw=A, btn low 8 cycles then high -> exactly one wr_pulse, wr_idx=0, digits[3:0]=A, all other nibbles 0.
- Long press then write: btn low 30 cycles -> cursor=1, no wr_pulse; then sw=5 with a short press -> digits[7:4]=5, wr_idx=1.
- Wrap: 6 long presses -> cursor goes 1,2,3,4,5,0.
- Bounce: 2-cycle low glitches repeated every 3 cycles for 40 cycles -> no state change and no wr_pulse. In IDLE, blank[cursor] toggles every 8 cycles.
- Shift variant (SEG_ENTRY_SHIFT_EN): short presses with sw=1,2,3 -> digits[11:0]=0x123. Long press -> digits all 0.
